// File: rtl/fp_addsub_controller.sv
// Request/response front end for a multi-cycle float adder/subtractor: issues one
// operation, masks the adder's stale valid, times out, and returns the tagged result.
module fp_addsub_controller #(
    parameter int PRECISION      = 32,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PRECISION-1:0] req_a,
    input  logic [PRECISION-1:0] req_b,
    input  logic                 req_op,
    input  logic [TAG_W-1:0]     req_tag,
    output logic [PRECISION-1:0] fa_inA,
    output logic [PRECISION-1:0] fa_inB,
    output logic                 fa_op,
    output logic                 fa_load,
    input  logic [PRECISION-1:0] fa_out,
    input  logic                 fa_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PRECISION-1:0] rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid is never withdrawn by the DUT before its transfer, and payloads are held stable.

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [63:0] QNAN_W = (PRECISION == 64) ? 64'h7FF8000000000000
                                                       : 64'h0000_0000_7FC0_0000;
    localparam logic [PRECISION-1:0] QNAN = QNAN_W[PRECISION-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [PRECISION-1:0] a_q, a_d;
    logic [PRECISION-1:0] b_q, b_d;
    logic                 op_q, op_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [PRECISION-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]     op_count_q, op_count_d;
    logic                 ready_c;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tag_d      = tag_q;
        wcnt_d     = wcnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        op_count_d = op_count_q;
        ready_c    = 1'b0;

        case (state_q)
            S_IDLE: ready_c = 1'b1;
            S_RESP: ready_c = rsp_ready;
            default: ready_c = 1'b0;
        endcase

        if (req_valid && ready_c) begin
            a_d   = req_a;
            b_d   = req_b;
            op_d  = req_op;
            tag_d = req_tag;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_ARM;
            S_ARM: begin
                // fa_valid may still be high from the previous op; it is not sampled here.
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fa_valid) begin
                    rsp_data_d = fa_out;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (wcnt_q == WAIT_LAST) begin
                    rsp_data_d = QNAN;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (op_count_q != '1) op_count_d = op_count_q + 1'b1;
                    state_d = req_valid ? S_LOAD : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            tag_q      <= '0;
            wcnt_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            wcnt_q     <= wcnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            op_count_q <= op_count_d;
        end
    end

    // Gated by rst_n so the accept strobe is low while reset is held.
    assign req_ready = ready_c & rst_n;
    assign fa_inA    = a_q;
    assign fa_inB    = b_q;
    assign fa_op     = op_q;
    assign fa_load   = (state_q == S_LOAD);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_addsub_controller.sv
// Directed bench for fp_addsub_controller with a cycle-scripted adder stub.
module tb_fp_addsub_controller;

    localparam int P     = 32;
    localparam int TW    = 4;
    localparam int CW    = 3;
    localparam int TMO   = 64;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [P-1:0]  req_a;
    logic [P-1:0]  req_b;
    logic          req_op;
    logic [TW-1:0] req_tag;
    logic [P-1:0]  fa_inA;
    logic [P-1:0]  fa_inB;
    logic          fa_op;
    logic          fa_load;
    logic [P-1:0]  fa_out;
    logic          fa_valid;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [P-1:0]  rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic          busy;
    logic [CW-1:0] op_count;

    int n_checks;
    int n_errors;
    int exp_count;
    int load_pulses;

    // stub configuration: k counts cycles since load (0 = LOAD, 1 = ARM, 2 = first WAIT)
    int           stub_k;
    int           stub_valid_at;
    logic         stub_stale;
    logic [P-1:0] stub_res;
    logic [P-1:0] stub_stale_out;

    fp_addsub_controller #(
        .PRECISION(P),
        .TAG_W(TW),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .req_tag(req_tag),
        .fa_inA(fa_inA),
        .fa_inB(fa_inB),
        .fa_op(fa_op),
        .fa_load(fa_load),
        .fa_out(fa_out),
        .fa_valid(fa_valid),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_tag(rsp_tag),
        .rsp_err(rsp_err),
        .busy(busy),
        .op_count(op_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // adder stub, driven on the falling edge so values are settled at the next rising edge
    always @(negedge clk) begin
        if (fa_load) begin
            stub_k = 0;
            load_pulses++;
        end else if (stub_k < 100000) begin
            stub_k++;
        end
        if (stub_k >= stub_valid_at) begin
            fa_valid = 1'b1;
            fa_out   = stub_res;
        end else if (stub_stale && stub_k <= 1) begin
            fa_valid = 1'b1;
            fa_out   = stub_stale_out;
        end else begin
            fa_valid = 1'b0;
            fa_out   = stub_stale_out;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // drivers (called at a falling edge, return at a falling edge)
    task automatic send_req(input logic [P-1:0] a, input logic [P-1:0] b,
                            input logic op, input logic [TW-1:0] tag);
        int t;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_tag   = tag;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("req_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("rsp_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic handoff();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (exp_count < (1 << CW) - 1) exp_count++;
        check("op_count", 64'(op_count), 64'(exp_count));
    endtask

    task automatic config_stub(input int valid_at, input logic stale,
                               input logic [P-1:0] res, input logic [P-1:0] stale_out);
        stub_valid_at  = valid_at;
        stub_stale     = stale;
        stub_res       = res;
        stub_stale_out = stale_out;
    endtask

    task automatic run_op(input string name, input logic [P-1:0] a, input logic [P-1:0] b,
                          input logic op, input logic [TW-1:0] tag,
                          input logic [P-1:0] exp_data, input logic exp_err, input int exp_lat);
        int lat;
        send_req(a, b, op, tag);
        check({name, "_load"}, 64'(fa_load), 64'd1);
        check({name, "_inA"}, 64'(fa_inA), 64'(a));
        check({name, "_inB"}, 64'(fa_inB), 64'(b));
        check({name, "_op"}, 64'(fa_op), 64'(op));
        wait_rsp(lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_data"}, 64'(rsp_data), 64'(exp_data));
        check({name, "_tag"}, 64'(rsp_tag), 64'(tag));
        check({name, "_err"}, 64'(rsp_err), 64'(exp_err));
        handoff();
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int loads0;
        logic bad;
        logic [P-1:0] held_data;
        logic [TW-1:0] held_tag;

        n_checks    = 0;
        n_errors    = 0;
        exp_count   = 0;
        load_pulses = 0;
        stub_k      = 100000;
        config_stub(2, 1'b0, 32'h0, 32'h0);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = 1'b0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        fa_valid  = 1'b0;
        fa_out    = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_fa_load", 64'(fa_load), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'd1);
        load_pulses = 0;

        // 1.0 + 2.0 = 3.0, result one WAIT cycle after ARM
        config_stub(2, 1'b0, 32'h40400000, 32'h0);
        run_op("add", 32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 1'b0, 4);

        // 3.0 - 1.0 = 2.0, exactly one load pulse
        loads0 = load_pulses;
        config_stub(4, 1'b0, 32'h40000000, 32'h0);
        run_op("sub", 32'h40400000, 32'h3F800000, 1'b1, 4'd9, 32'h40000000, 1'b0, 6);
        check("sub_one_load", 64'(load_pulses - loads0), 64'd1);

        // back-pressure for 10 cycles with a request waiting, then back-to-back accept
        config_stub(2, 1'b0, 32'h40800000, 32'h0);
        send_req(32'h40000000, 32'h40000000, 1'b0, 4'd3);
        wait_rsp(lat);
        check("bp_data", 64'(rsp_data), 64'h40800000);
        held_data = rsp_data;
        held_tag  = rsp_tag;
        config_stub(2, 1'b0, 32'h40000000, 32'h0);
        req_valid = 1'b1;
        req_a     = 32'h3F800000;
        req_b     = 32'h3F800000;
        req_op    = 1'b0;
        req_tag   = 4'd7;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_tag !== held_tag ||
                req_ready !== 1'b0 || fa_load !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("bp_hold_stable", 64'(bad), 64'd0);
        check("bp_tag", 64'(held_tag), 64'd3);
        rsp_ready = 1'b1;
        #1;
        check("bp_pass_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        if (exp_count < (1 << CW) - 1) exp_count++;
        check("bp_op_count", 64'(op_count), 64'(exp_count));
        check("b2b_load", 64'(fa_load), 64'd1);
        check("b2b_inA", 64'(fa_inA), 64'h3F800000);
        wait_rsp(lat);
        check("b2b_lat", 64'(lat), 64'd4);
        check("b2b_data", 64'(rsp_data), 64'h40000000);
        check("b2b_tag", 64'(rsp_tag), 64'd7);
        handoff();

        // stale valid still high through LOAD and ARM must not be captured
        config_stub(5, 1'b1, 32'h41200000, 32'hDEADBEEF);
        run_op("stale", 32'h40A00000, 32'h40A00000, 1'b0, 4'd2, 32'h41200000, 1'b0, 7);

        // adder never answers: timeout after 64 WAIT cycles
        config_stub(1000, 1'b0, 32'h0, 32'h0);
        run_op("tmo", 32'h3F800000, 32'h3F800000, 1'b0, 4'd11, 32'h7FC00000, 1'b1, 67);

        // drive op_count into saturation at 7
        config_stub(2, 1'b0, 32'h40400000, 32'h0);
        run_op("sat7", 32'h3F800000, 32'h40000000, 1'b0, 4'd1, 32'h40400000, 1'b0, 4);
        run_op("sat8", 32'h3F800000, 32'h40000000, 1'b0, 4'd4, 32'h40400000, 1'b0, 4);
        check("sat_hold", 64'(op_count), 64'd7);

        // reset in the middle of WAIT abandons the op
        config_stub(1000, 1'b0, 32'h0, 32'h0);
        send_req(32'h40E00000, 32'h3F800000, 1'b1, 4'd13);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_outs", {rsp_valid, rsp_err, fa_load, fa_op, rsp_tag, op_count}, 64'd0);
        check("mid_rst_inA", 64'(fa_inA), 64'd0);
        check("mid_rst_inB", 64'(fa_inB), 64'd0);
        check("mid_rst_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        check("post_rst_quiet", 64'(bad), 64'd0);

        config_stub(3, 1'b0, 32'h40000000, 32'h0);
        run_op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 4'd6, 32'h40000000, 1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
